// File: rtl/ram_sp_be_clr_if.sv
// Access bus for the byte-enabled scratch RAM: request, clear pulse and read-back.
// The client drives the master side and must hold off while busy is high.
interface ram_sp_be_clr_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                      cen;
    logic                      wen;
    logic [DATA_WIDTH/8-1:0]   be;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [DATA_WIDTH-1:0]     din;
    logic                      clr;
    logic                      busy;
    logic [DATA_WIDTH-1:0]     dout;
    logic                      dout_valid;

    modport master (
        output cen, wen, be, addr, din, clr,
        input  busy, dout, dout_valid
    );

    modport slave (
        input  cen, wen, be, addr, din, clr,
        output busy, dout, dout_valid
    );
endinterface

// File: rtl/ram_sp_be_clr.sv
// Single-port RAM with byte-lane writes, selectable read-during-write behaviour and
// a clear engine that zeroes every word after reset or on a clr pulse.
module ram_sp_be_clr #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int RDW_MODE   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    ram_sp_be_clr_if.slave       bus
);
    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int NUM_LANES = DATA_WIDTH / 8;

    typedef enum logic {IDLE, CLEAR} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
    logic                    dout_valid_q;
    logic                    clearing;
    logic                    acc;
    logic                    wr_acc;
    logic                    rd_acc;
    logic [DATA_WIDTH-1:0]   dout_w;

    assign clearing = (state_q == CLEAR);
    // A clr pulse in IDLE takes priority over a simultaneous access.
    assign acc      = bus.cen && !clearing && !bus.clr;
    assign wr_acc   = acc && bus.wen;
    assign rd_acc   = acc && !bus.wen;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= CLEAR;
            clr_addr_q   <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            dout_valid_q <= rd_acc;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            IDLE: begin
                if (bus.clr) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
            CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (&clr_addr_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // Each byte lane is its own narrow RAM so byte writes map onto plain block RAM.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [7:0]            mem_q [DEPTH];
            logic [7:0]            lane_dout_q;
            logic                  lane_we;
            logic [ADDR_WIDTH-1:0] lane_waddr;
            logic [7:0]            lane_wdata;
            logic [7:0]            lane_din;

            assign lane_din   = bus.din[8*gi +: 8];
            assign lane_we    = clearing || (wr_acc && bus.be[gi]);
            assign lane_waddr = clearing ? clr_addr_q : bus.addr;
            assign lane_wdata = clearing ? 8'h00 : lane_din;

            always_ff @(posedge clk) begin
                if (!reset && lane_we) begin
                    mem_q[lane_waddr] <= lane_wdata;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    lane_dout_q <= '0;
                end else if (acc) begin
                    if ((RDW_MODE != 0) && wr_acc && bus.be[gi]) begin
                        lane_dout_q <= lane_din;
                    end else begin
                        lane_dout_q <= mem_q[bus.addr];
                    end
                end
            end

            assign dout_w[8*gi +: 8] = lane_dout_q;
        end
    endgenerate

    assign bus.busy       = reset || clearing;
    assign bus.dout       = dout_w;
    assign bus.dout_valid = dout_valid_q;
endmodule

// File: tb/tb_ram_sp_be_clr.sv
// Bench for ram_sp_be_clr: both read-during-write variants run side by side against
// a cycle-level reference model, with directed steps followed by random traffic.
module tb_ram_sp_be_clr;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          cen, wen, clr;
    logic [3:0]    be;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;

    int n_checks = 0;
    int n_pass   = 0;

    ram_sp_be_clr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
    ram_sp_be_clr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

    assign bus0.cen = cen;  assign bus1.cen = cen;
    assign bus0.wen = wen;  assign bus1.wen = wen;
    assign bus0.be = be;    assign bus1.be = be;
    assign bus0.addr = addr; assign bus1.addr = addr;
    assign bus0.din = din;  assign bus1.din = din;
    assign bus0.clr = clr;  assign bus1.clr = clr;

    ram_sp_be_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(0)) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    ram_sp_be_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    always #5 clk = ~clk;

    // Reference model: memory image, remaining clear cycles, expected outputs.
    logic [DW-1:0] mem_m [DEPTH];
    int            clr_left = 0;
    logic [DW-1:0] dout0_m = '0;
    logic [DW-1:0] dout1_m = '0;
    logic          valid_m = 1'b0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic model_edge();
        logic [DW-1:0] old_w, new_w;
        if (reset) begin
            clr_left = DEPTH;
            dout0_m  = '0;
            dout1_m  = '0;
            valid_m  = 1'b0;
        end else if (clr_left > 0) begin
            mem_m[DEPTH - clr_left] = '0;
            clr_left--;
            valid_m = 1'b0;
        end else if (clr) begin
            clr_left = DEPTH;
            valid_m  = 1'b0;
        end else if (cen && wen) begin
            old_w = mem_m[addr];
            new_w = old_w;
            for (int b = 0; b < 4; b++)
                if (be[b]) new_w[8*b +: 8] = din[8*b +: 8];
            mem_m[addr] = new_w;
            dout0_m = old_w;
            dout1_m = new_w;
            valid_m = 1'b0;
        end else if (cen) begin
            dout0_m = mem_m[addr];
            dout1_m = mem_m[addr];
            valid_m = 1'b1;
        end else begin
            valid_m = 1'b0;
        end
    endtask

    task automatic step();
        logic busy_m;
        @(posedge clk);
        model_edge();
        #1;
        busy_m = reset || (clr_left > 0);
        chk("busy0", {31'b0, bus0.busy}, {31'b0, busy_m});
        chk("busy1", {31'b0, bus1.busy}, {31'b0, busy_m});
        chk("valid0", {31'b0, bus0.dout_valid}, {31'b0, valid_m});
        chk("valid1", {31'b0, bus1.dout_valid}, {31'b0, valid_m});
        chk("dout0", bus0.dout, dout0_m);
        chk("dout1", bus1.dout, dout1_m);
    endtask

    task automatic set_idle();
        cen = 1'b0; wen = 1'b0; clr = 1'b0; be = 4'h0;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        cen = 1'b1; wen = 1'b0; addr = a;
        step();
        set_idle();
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] b);
        cen = 1'b1; wen = 1'b1; addr = a; din = d; be = b;
        step();
        set_idle();
    endtask

    // Steps until busy drops (bounded) and checks how many busy cycles remained.
    task automatic wait_busy(input string tag, input int exp_cycles);
        int n = 0;
        while (bus0.busy === 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk(tag, n, exp_cycles);
    endtask

    initial begin
        set_idle();
        addr = '0; din = '0;
        reset = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 'x;

        step(); step();
        chk("rst_dout", bus0.dout, 32'h0);
        reset = 1'b0;
        wait_busy("busy_after_reset", DEPTH);

        do_read(5'h00); chk("rd00", bus0.dout, 32'h0);
        do_read(5'h1F); chk("rd1F", bus1.dout, 32'h0);
        do_read(5'h0A); chk("rd0A_valid", {31'b0, bus0.dout_valid}, 32'h1);

        for (int k = 1; k < DEPTH; k++) do_write(AW'(k), DW'(k), 4'hF);
        for (int k = 0; k < DEPTH; k++) begin
            do_read(AW'(k));
            chk("rdback", bus0.dout, DW'(k));
            step();
        end

        do_write(5'h1A, 32'hFFFF_FFFF, 4'b0101);
        chk("rdw_old", bus0.dout, 32'h0000_001A);
        chk("rdw_new", bus1.dout, 32'h00FF_00FF);
        do_read(5'h1A); chk("merge", bus0.dout, 32'h00FF_00FF);
        do_write(5'h03, 32'hDEAD_BEEF, 4'h0);
        do_read(5'h03); chk("be0_noop", bus0.dout, 32'h3);

        cen = 1'b1; wen = 1'b1; addr = 5'h05; din = 32'h1234_5678; be = 4'hF; clr = 1'b1;
        step();
        set_idle();
        cen = 1'b1; wen = 1'b0; addr = 5'h07;
        step();
        chk("rd_busy_valid", {31'b0, bus0.dout_valid}, 32'h0);
        set_idle();
        wait_busy("busy_after_clr", DEPTH - 1);
        do_read(5'h05); chk("clr05", bus0.dout, 32'h0);
        do_read(5'h1A); chk("clr1A", bus1.dout, 32'h0);

        clr = 1'b1; step(); clr = 1'b0;
        for (int i = 0; i < 10; i++) step();
        reset = 1'b1; step(); reset = 1'b0;
        wait_busy("busy_reset_midclear", DEPTH);

        clr = 1'b1; step(); clr = 1'b0;
        for (int i = 0; i < 5; i++) step();
        clr = 1'b1; step(); clr = 1'b0;
        wait_busy("busy_second_clr", DEPTH - 6);

        for (int i = 0; i < 600; i++) begin
            cen   = $urandom_range(0, 3) != 0;
            wen   = $urandom_range(0, 1) != 0;
            be    = 4'($urandom);
            addr  = AW'($urandom);
            din   = $urandom;
            clr   = $urandom_range(0, 59) == 0;
            reset = $urandom_range(0, 249) == 0;
            step();
        end
        set_idle();
        reset = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
